// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default widths, handshake FSM state codes, write-back source select.
package mem_stage_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int RW_DEFAULT = 5;

  // Handshake FSM state codes; kept as plain 1-bit constants so older
  // blocks that compare against raw state bits keep working.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Source of the MEM/WB write-back value.
  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC  = 2'd2
  } wb_sel_e;

  // Link address beats memory data, which beats the ALU result.
  function automatic wb_sel_e wb_select(input logic alu_mem_or_pc, input logic alu_or_mem);
    if (alu_mem_or_pc) begin
      return WB_SEL_PC;
    end
    if (alu_or_mem) begin
      return WB_SEL_MEM;
    end
    return WB_SEL_ALU;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bundle between the MEM stage and the memory.
// Latency: n/a (wires only).
// Backpressure: the memory holds off completion by withholding dmem_ack.
// Signals: dmem_req/we/addr/wdata (stage -> memory), dmem_ack/rdata (memory -> stage).
interface mem_stage_ctrl_if #(
  parameter int DW = mem_stage_pkg::DW_DEFAULT
);
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_handshake_fsm.sv
// Req/ack sequencer for one data-memory access, with timeout and sticky bus error.
// Latency: request is combinational from the op bits; completes in the ack cycle.
// Backpressure: stall stays high until ack (or timeout) while a request is open.
// Ports: clk/reset; mem_rd/mem_wr/addr_in/wdata_in from EX/MEM; dmem master bundle;
//        stall, acc_done (ack cycle), timeout (abort cycle), bus_error (sticky).
module mem_handshake_fsm
  import mem_stage_pkg::*;
#(
  parameter int DW          = DW_DEFAULT,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic [DW-1:0]    addr_in,
  input  logic [DW-1:0]    wdata_in,
  mem_stage_ctrl_if.master dmem,
  output logic             stall,
  output logic             acc_done,
  output logic             timeout,
  output logic             bus_error
);

  localparam bit              TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_error_q, bus_error_d;
  logic [DW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             we_q, we_d;

  logic             req;
  logic             we;
  logic [DW-1:0]    addr;
  logic [DW-1:0]    wdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_error_d = bus_error_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    req         = 1'b0;
    we          = 1'b0;
    addr        = '0;
    wdata       = '0;
    acc_done    = 1'b0;
    timeout     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_rd | mem_wr) begin
          req   = 1'b1;
          we    = mem_wr;
          addr  = addr_in;
          wdata = wdata_in;
          if (dmem.dmem_ack) begin
            // Same-cycle completion: no WAIT visit, no stall.
            acc_done = 1'b1;
          end else begin
            // Snapshot the request so the bus stays stable in WAIT
            // independent of what the upstream register does.
            state_d = ST_WAIT;
            cnt_d   = '0;
            addr_d  = addr_in;
            wdata_d = wdata_in;
            we_d    = mem_wr;
          end
        end
      end
      default: begin
        req   = 1'b1;
        we    = we_q;
        addr  = addr_q;
        wdata = wdata_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem.dmem_ack) begin
          acc_done = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          // Last allowed WAIT cycle: abort. The pipeline is released in this
          // cycle so the faulting op retires (as a bubble) instead of retrying.
          timeout     = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = '0;
          bus_error_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
    end
  end

  // Combinational outputs are gated by reset so an open request drops the
  // instant reset asserts, even while EX/MEM still presents a memory op.
  assign dmem.dmem_req   = req & reset;
  assign dmem.dmem_we    = we & reset;
  assign dmem.dmem_addr  = reset ? addr : '0;
  assign dmem.dmem_wdata = reset ? wdata : '0;
  assign stall           = req & ~acc_done & ~timeout & reset;
  assign bus_error       = bus_error_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage control: branch/jump redirect, data-memory handshake, MEM/WB register.
// Latency: EX/MEM -> MEM/WB one falling edge; memory ops one edge after ack.
// Backpressure: stall freezes upstream stages while a memory access is open.
// Ports: clk/reset; in_* EX/MEM fields; dmem master bundle; stall, pc_redirect,
//        pc_target, flush, bus_error; wb_RegWrite/wb_WriteRegister/wb_WriteData.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DW          = DW_DEFAULT,
  parameter int RW          = RW_DEFAULT,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_Zero,
  input  logic [DW-1:0]    in_ALUResult,
  input  logic [DW-1:0]    in_ReadData1,
  input  logic [DW-1:0]    in_WriteData,
  input  logic [DW-1:0]    in_JumpAddress,
  input  logic [DW-1:0]    in_BranchAddress,
  input  logic [DW-1:0]    in_PC_4,
  input  logic [RW-1:0]    in_WriteRegister,
  input  logic             in_CtrlRegWrite,
  input  logic             in_CtrlJump,
  input  logic             in_CtrlMemRead,
  input  logic             in_CtrlMemWrite,
  input  logic             in_CtrlALUOrMem,
  input  logic             in_CtrlBranchEquals,
  input  logic             in_CtrlBranchNotEquals,
  input  logic             in_CtrlRegisterOrPC,
  input  logic             in_CtrlALUMemOrPC,
  mem_stage_ctrl_if.master dmem,
  output logic             stall,
  output logic             pc_redirect,
  output logic [DW-1:0]    pc_target,
  output logic             flush,
  output logic             bus_error,
  output logic             wb_RegWrite,
  output logic [RW-1:0]    wb_WriteRegister,
  output logic [DW-1:0]    wb_WriteData
);

  logic          mem_done;
  logic          mem_timeout;
  logic          take;
  logic [DW-1:0] target;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] wb_data;

  logic          wb_reg_write_q, wb_reg_write_d;
  logic [RW-1:0] wb_write_register_q, wb_write_register_d;
  logic [DW-1:0] wb_write_data_q, wb_write_data_d;

  mem_handshake_fsm #(
    .DW          (DW),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_handshake (
    .clk       (clk),
    .reset     (reset),
    .mem_rd    (in_CtrlMemRead),
    .mem_wr    (in_CtrlMemWrite),
    .addr_in   (in_ALUResult),
    .wdata_in  (in_WriteData),
    .dmem      (dmem),
    .stall     (stall),
    .acc_done  (mem_done),
    .timeout   (mem_timeout),
    .bus_error (bus_error)
  );

  // Jump wins over branch when both are flagged.
  always_comb begin
    take = (in_CtrlBranchEquals & in_Zero) | (in_CtrlBranchNotEquals & ~in_Zero) | in_CtrlJump;
    if (in_CtrlJump) begin
      target = in_CtrlRegisterOrPC ? in_ReadData1 : in_JumpAddress;
    end else begin
      target = in_BranchAddress;
    end
  end

  // A redirect while stalled would be re-issued on every held cycle, so it
  // is only raised once the op is actually leaving EX/MEM.
  assign pc_redirect = take & ~stall & reset;
  assign flush       = take & ~stall & reset;
  assign pc_target   = (reset & ~stall) ? target : '0;

  // Read data is only meaningful in the ack cycle; elsewhere it reads as 0.
  assign mem_data = mem_done ? dmem.dmem_rdata : '0;

  always_comb begin
    wb_data = in_ALUResult;
    case (wb_select(in_CtrlALUMemOrPC, in_CtrlALUOrMem))
      WB_SEL_PC:  wb_data = in_PC_4;
      WB_SEL_MEM: wb_data = mem_data;
      default:    wb_data = in_ALUResult;
    endcase
  end

  // Stall and timeout both retire a bubble: write enable drops, payload holds.
  always_comb begin
    wb_reg_write_d      = 1'b0;
    wb_write_register_d = wb_write_register_q;
    wb_write_data_d     = wb_write_data_q;
    if (!stall && !mem_timeout) begin
      wb_reg_write_d      = in_CtrlRegWrite;
      wb_write_register_d = in_WriteRegister;
      wb_write_data_d     = wb_data;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      wb_reg_write_q      <= 1'b0;
      wb_write_register_q <= '0;
      wb_write_data_q     <= '0;
    end else begin
      wb_reg_write_q      <= wb_reg_write_d;
      wb_write_register_q <= wb_write_register_d;
      wb_write_data_q     <= wb_write_data_d;
    end
  end

  assign wb_RegWrite      = wb_reg_write_q;
  assign wb_WriteRegister = wb_write_register_q;
  assign wb_WriteData     = wb_write_data_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: per-instruction reference model feeding two scoreboards
// (per-cycle control outputs, write-back stream), checked by an independent monitor.
module tb_mem_stage_ctrl;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 16;

  logic          clk = 1'b1;
  logic          reset;
  logic          in_Zero;
  logic [DW-1:0] in_ALUResult, in_ReadData1, in_WriteData, in_JumpAddress;
  logic [DW-1:0] in_BranchAddress, in_PC_4;
  logic [RW-1:0] in_WriteRegister;
  logic          in_CtrlRegWrite, in_CtrlJump, in_CtrlMemRead, in_CtrlMemWrite;
  logic          in_CtrlALUOrMem, in_CtrlBranchEquals, in_CtrlBranchNotEquals;
  logic          in_CtrlRegisterOrPC, in_CtrlALUMemOrPC;
  logic          stall, pc_redirect, flush, bus_error, wb_RegWrite;
  logic [DW-1:0] pc_target, wb_WriteData;
  logic [RW-1:0] wb_WriteRegister;

  mem_stage_ctrl_if #(.DW(DW)) dif ();

  mem_stage_ctrl #(.DW(DW), .RW(RW), .MEM_TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .in_Zero(in_Zero), .in_ALUResult(in_ALUResult),
    .in_ReadData1(in_ReadData1), .in_WriteData(in_WriteData),
    .in_JumpAddress(in_JumpAddress), .in_BranchAddress(in_BranchAddress),
    .in_PC_4(in_PC_4), .in_WriteRegister(in_WriteRegister),
    .in_CtrlRegWrite(in_CtrlRegWrite), .in_CtrlJump(in_CtrlJump),
    .in_CtrlMemRead(in_CtrlMemRead), .in_CtrlMemWrite(in_CtrlMemWrite),
    .in_CtrlALUOrMem(in_CtrlALUOrMem), .in_CtrlBranchEquals(in_CtrlBranchEquals),
    .in_CtrlBranchNotEquals(in_CtrlBranchNotEquals),
    .in_CtrlRegisterOrPC(in_CtrlRegisterOrPC), .in_CtrlALUMemOrPC(in_CtrlALUMemOrPC),
    .dmem(dif), .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .flush(flush), .bus_error(bus_error), .wb_RegWrite(wb_RegWrite),
    .wb_WriteRegister(wb_WriteRegister), .wb_WriteData(wb_WriteData)
  );

  always #5 clk = ~clk;

  // One EX/MEM instruction plus the memory's behaviour for it.
  // lat = cycles without ack before the ack cycle; lat > TO never acks.
  typedef struct {
    logic        rw, jump, mr, mw, aluormem, beq, bne, regorpc, alumemorpc, zero;
    logic [31:0] alu, rd1, wd, ja, ba, pc4, rdata;
    logic [4:0]  wreg;
    int          lat;
  } instr_t;

  typedef struct {
    logic        stall, req, we, redirect, berr;
    logic [31:0] addr, wdata, target;
  } cyc_t;

  typedef struct {
    logic [4:0]  wreg;
    logic [31:0] data;
  } wb_t;

  cyc_t cyc_q[$];
  wb_t  wb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic model_berr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t nop();
    instr_t i;
    i = '{default: '0};
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i = nop();
    i.alu = $urandom; i.rd1 = $urandom; i.wd = $urandom; i.ja = $urandom;
    i.ba = $urandom;  i.pc4 = $urandom; i.rdata = $urandom;
    i.wreg = 5'($urandom); i.zero = 1'($urandom);
    case ($urandom_range(0, 4))
      0: begin
        i.rw = 1'b1; i.aluormem = ($urandom_range(0, 3) == 0);
      end
      1: begin
        i.mr = 1'b1; i.rw = 1'b1; i.aluormem = 1'b1;
        i.lat = ($urandom_range(0, 19) == 0) ? 100 : int'($urandom_range(0, 8));
      end
      2: begin
        i.mw = 1'b1; i.mr = ($urandom_range(0, 3) == 0);
        i.rw = ($urandom_range(0, 3) == 0); i.aluormem = 1'b1;
        i.lat = int'($urandom_range(0, 8));
      end
      3: begin
        if ($urandom_range(0, 1) == 0) i.beq = 1'b1; else i.bne = 1'b1;
      end
      default: begin
        i.jump = 1'b1; i.regorpc = 1'($urandom); i.alumemorpc = 1'($urandom);
        i.rw = i.alumemorpc; i.beq = 1'($urandom); i.bne = 1'($urandom);
      end
    endcase
    return i;
  endfunction

  task automatic drive(input instr_t i, input logic ack, input logic [31:0] rdata);
    in_Zero = i.zero; in_ALUResult = i.alu; in_ReadData1 = i.rd1; in_WriteData = i.wd;
    in_JumpAddress = i.ja; in_BranchAddress = i.ba; in_PC_4 = i.pc4;
    in_WriteRegister = i.wreg; in_CtrlRegWrite = i.rw; in_CtrlJump = i.jump;
    in_CtrlMemRead = i.mr; in_CtrlMemWrite = i.mw; in_CtrlALUOrMem = i.aluormem;
    in_CtrlBranchEquals = i.beq; in_CtrlBranchNotEquals = i.bne;
    in_CtrlRegisterOrPC = i.regorpc; in_CtrlALUMemOrPC = i.alumemorpc;
    dif.dmem_ack = ack; dif.dmem_rdata = rdata;
  endtask

  // Holds the instruction in EX/MEM for as many cycles as the model says it
  // stalls, acting as the memory, and queues what each cycle must show.
  task automatic run_instr(input instr_t i, input int max_cyc);
    logic        mem, last, tout, ack, take;
    logic [31:0] rdata;
    int          full, ncyc;
    cyc_t        c;
    wb_t         w;
    mem  = i.mr | i.mw;
    full = !mem ? 1 : (i.lat <= TO) ? i.lat + 1 : TO + 1;
    ncyc = (full > max_cyc) ? max_cyc : full;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      #1;
      last  = (k == full - 1);
      tout  = mem && (i.lat > TO) && last;
      ack   = mem ? (k == i.lat) : 1'($urandom_range(0, 1));
      rdata = ack ? i.rdata : $urandom;
      drive(i, ack, rdata);
      take       = (i.beq && i.zero) || (i.bne && !i.zero) || i.jump;
      c.stall    = mem && !last;
      c.req      = mem;
      c.we       = i.mw;
      c.addr     = i.alu;
      c.wdata    = i.wd;
      c.redirect = take && !c.stall;
      c.target   = i.jump ? (i.regorpc ? i.rd1 : i.ja) : i.ba;
      c.berr     = model_berr;
      cyc_q.push_back(c);
      if (last) begin
        if (tout) begin
          model_berr = 1'b1;
        end else if (i.rw) begin
          w.wreg = i.wreg;
          w.data = i.alumemorpc ? i.pc4 : (i.aluormem ? ((mem && ack) ? rdata : 32'h0) : i.alu);
          wb_q.push_back(w);
        end
      end
    end
  endtask

  // Monitor: DUT changes state on falling edges, so sample on rising edges.
  initial begin : monitor
    cyc_t c;
    wb_t  w;
    forever begin
      @(posedge clk);
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("stall", 32'(stall), 32'(c.stall));
        chk("dmem_req", 32'(dif.dmem_req), 32'(c.req));
        chk("pc_redirect", 32'(pc_redirect), 32'(c.redirect));
        chk("flush", 32'(flush), 32'(c.redirect));
        chk("bus_error", 32'(bus_error), 32'(c.berr));
        if (c.req) begin
          chk("dmem_addr", dif.dmem_addr, c.addr);
          chk("dmem_we", 32'(dif.dmem_we), 32'(c.we));
          if (c.we) chk("dmem_wdata", dif.dmem_wdata, c.wdata);
        end
        if (c.redirect) chk("pc_target", pc_target, c.target);
      end
      if (wb_RegWrite === 1'b1) begin
        if (wb_q.size() == 0) begin
          chk("wb_unexpected_write", 32'(wb_RegWrite), 32'h0);
        end else begin
          w = wb_q.pop_front();
          chk("wb_WriteRegister", 32'(wb_WriteRegister), 32'(w.wreg));
          chk("wb_WriteData", wb_WriteData, w.data);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    instr_t i;
    // Reset with a load and a jump presented: nothing may leak out.
    reset = 1'b0;
    i = nop(); i.mr = 1'b1; i.jump = 1'b1; i.alu = 32'h44; i.ja = 32'h88; i.rw = 1'b1;
    drive(i, 1'b1, 32'h5555_aaaa);
    #2;
    chk("rst_req", 32'(dif.dmem_req), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_addr", dif.dmem_addr, 32'h0);
    chk("rst_redirect", 32'(pc_redirect), 32'h0);
    chk("rst_target", pc_target, 32'h0);
    chk("rst_bus_error", 32'(bus_error), 32'h0);
    chk("rst_wb_regwrite", 32'(wb_RegWrite), 32'h0);
    chk("rst_wb_data", wb_WriteData, 32'h0);
    #20;
    drive(nop(), 1'b0, 32'h0);
    @(posedge clk); #2; reset = 1'b1;

    // Directed cases.
    i = nop(); i.rw = 1'b1; i.alu = 32'h10; i.wreg = 5'd8;                         run_instr(i, 100);
    i = nop(); i.mr = 1'b1; i.rw = 1'b1; i.aluormem = 1'b1; i.alu = 32'h100;
    i.wreg = 5'd9; i.rdata = 32'hDEAD_BEEF; i.lat = 4;                               run_instr(i, 100);
    i = nop(); i.mw = 1'b1; i.alu = 32'h40; i.wd = 32'h1234; i.lat = 0;             run_instr(i, 100);
    i = nop(); i.bne = 1'b1; i.zero = 1'b0; i.ba = 32'h200;                          run_instr(i, 100);
    i = nop(); i.beq = 1'b1; i.zero = 1'b0; i.ba = 32'h300;                          run_instr(i, 100);
    i = nop(); i.jump = 1'b1; i.regorpc = 1'b1; i.rd1 = 32'h3000; i.ja = 32'h5000;
    i.alumemorpc = 1'b1; i.pc4 = 32'h24; i.rw = 1'b1; i.wreg = 5'd31;              run_instr(i, 100);
    i = nop(); i.mr = 1'b1; i.rw = 1'b1; i.aluormem = 1'b1; i.alu = 32'h180;
    i.wreg = 5'd0; i.rdata = 32'hCAFE_F00D; i.lat = TO;                               run_instr(i, 100);
    i = nop(); i.mr = 1'b1; i.rw = 1'b1; i.aluormem = 1'b1; i.alu = 32'h1C0;
    i.wreg = 5'd4; i.lat = 1000;                                                      run_instr(i, 100);
    run_instr(nop(), 100);

    for (int n = 0; n < 300; n++) run_instr(rand_instr(), 100);

    // Reset in the middle of an open load.
    i = nop(); i.mr = 1'b1; i.rw = 1'b1; i.aluormem = 1'b1; i.alu = 32'h2C0; i.lat = 1000;
    run_instr(i, 6);
    @(posedge clk); #2;
    chk("pre_rst_req", 32'(dif.dmem_req), 32'h1);
    chk("pre_rst_bus_error", 32'(bus_error), 32'(model_berr));
    reset = 1'b0;
    #1;
    chk("midwait_rst_req", 32'(dif.dmem_req), 32'h0);
    chk("midwait_rst_stall", 32'(stall), 32'h0);
    chk("midwait_rst_bus_error", 32'(bus_error), 32'h0);
    chk("midwait_rst_wb_regwrite", 32'(wb_RegWrite), 32'h0);
    model_berr = 1'b0;
    drive(nop(), 1'b0, 32'h0);
    @(posedge clk); @(posedge clk); #2; reset = 1'b1;

    i = nop(); i.mr = 1'b1; i.rw = 1'b1; i.aluormem = 1'b1; i.alu = 32'h300;
    i.wreg = 5'd12; i.rdata = 32'h0BAD_F00D; i.lat = 2;                              run_instr(i, 100);
    for (int n = 0; n < 20; n++) run_instr(rand_instr(), 100);
    for (int n = 0; n < 3; n++) run_instr(nop(), 100);
    @(posedge clk); @(posedge clk); #2;
    chk("wb_pending", 32'(wb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
